// File: rtl/serving_brg_pkg.sv
// Shared types and helpers for the serving bridge master: FSM encoding,
// timeout counter sizing and byte-enable to bit-mask expansion.
package serving_brg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_REQ     = 3'd2,
    ST_RESP    = 3'd3,
    ST_RELEASE = 3'd4
  } brg_state_t;

  // Width needed to count 0..timeout-1, never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/serving_brg_master.sv
// Host-side initiator for the serving bridge port: one read/write command at a
// time, ack wait with timeout, masked read data returned on a response channel.
module serving_brg_master
  import serving_brg_pkg::*;
#(
  parameter int AW      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // Both channels: a transfer happens on a rising clock edge where valid and
  // ready are both high; the initiator holds its payload stable until then.
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_adr,
  input  logic [31:0]   i_cmd_dat,
  input  logic [3:0]    i_cmd_sel,
  input  logic          i_cmd_rsrc,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [31:0]   o_rsp_dat,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_adr_brg,
  output logic [31:0]   o_data_brg,
  output logic          o_stb_brg,
  output logic          o_wen_brg,
  output logic [3:0]    o_sel_brg,
  input  logic [31:0]   i_rdt_brg,
  input  logic          i_ack_brg,
  output logic          o_sel_wadr,
  output logic          o_sel_wdata,
  output logic          o_sel_wen,
  output logic          o_sel_radr,
  output logic          o_sel_rdata,
  output logic          o_busy,
  output logic [2:0]    o_dbg_state
);

  localparam int CW = cnt_width(TIMEOUT);

  brg_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, stb_nxt, wen_nxt, busy_nxt;
  logic [31:0]   rsp_dat_nxt, data_nxt;
  logic [AW-1:0] adr_nxt;
  logic [3:0]    sel_nxt;
  logic          sel_wadr_nxt, sel_wdata_nxt, sel_wen_nxt, sel_radr_nxt, sel_rdata_nxt;

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_dat   <= '0;
      o_adr_brg   <= '0;
      o_data_brg  <= '0;
      o_stb_brg   <= 1'b0;
      o_wen_brg   <= 1'b0;
      o_sel_brg   <= '0;
      o_sel_wadr  <= 1'b0;
      o_sel_wdata <= 1'b0;
      o_sel_wen   <= 1'b0;
      o_sel_radr  <= 1'b0;
      o_sel_rdata <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_cmd_ready <= cmd_ready_nxt;
      o_rsp_valid <= rsp_valid_nxt;
      o_rsp_err   <= rsp_err_nxt;
      o_rsp_dat   <= rsp_dat_nxt;
      o_adr_brg   <= adr_nxt;
      o_data_brg  <= data_nxt;
      o_stb_brg   <= stb_nxt;
      o_wen_brg   <= wen_nxt;
      o_sel_brg   <= sel_nxt;
      o_sel_wadr  <= sel_wadr_nxt;
      o_sel_wdata <= sel_wdata_nxt;
      o_sel_wen   <= sel_wen_nxt;
      o_sel_radr  <= sel_radr_nxt;
      o_sel_rdata <= sel_rdata_nxt;
      o_busy      <= busy_nxt;
    end
  end

  // The bridge output registers double as the command latch: we and sel are
  // read back from o_wen_brg / o_sel_brg when the ack arrives.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cmd_ready_nxt = o_cmd_ready;
    rsp_valid_nxt = o_rsp_valid;
    rsp_err_nxt   = o_rsp_err;
    rsp_dat_nxt   = o_rsp_dat;
    adr_nxt       = o_adr_brg;
    data_nxt      = o_data_brg;
    stb_nxt       = o_stb_brg;
    wen_nxt       = o_wen_brg;
    sel_nxt       = o_sel_brg;
    sel_wadr_nxt  = o_sel_wadr;
    sel_wdata_nxt = o_sel_wdata;
    sel_wen_nxt   = o_sel_wen;
    sel_radr_nxt  = o_sel_radr;
    sel_rdata_nxt = o_sel_rdata;

    case (state)
      ST_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          if (i_cmd_sel == 4'b0000) begin
            state_nxt     = ST_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_dat_nxt   = '0;
          end else begin
            state_nxt     = ST_SETUP;
            adr_nxt       = i_cmd_adr;
            data_nxt      = i_cmd_dat;
            sel_nxt       = i_cmd_sel;
            wen_nxt       = i_cmd_we;
            sel_wadr_nxt  = i_cmd_we;
            sel_wdata_nxt = i_cmd_we;
            sel_wen_nxt   = i_cmd_we;
            sel_radr_nxt  = ~i_cmd_we;
            sel_rdata_nxt = ~i_cmd_we & i_cmd_rsrc;
          end
        end
      end
      ST_SETUP: begin
        state_nxt = ST_REQ;
        stb_nxt   = 1'b1;
        cnt_nxt   = '0;
      end
      ST_REQ: begin
        if (i_ack_brg) begin
          state_nxt     = ST_RESP;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_dat_nxt   = o_wen_brg ? 32'd0 : (i_rdt_brg & byte_mask(o_sel_brg));
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt     = ST_RESP;
          stb_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_dat_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_nxt     = ST_RELEASE;
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_dat_nxt   = '0;
          adr_nxt       = '0;
          data_nxt      = '0;
          wen_nxt       = 1'b0;
          sel_nxt       = '0;
          sel_wadr_nxt  = 1'b0;
          sel_wdata_nxt = 1'b0;
          sel_wen_nxt   = 1'b0;
          sel_radr_nxt  = 1'b0;
          sel_rdata_nxt = 1'b0;
        end
      end
      ST_RELEASE: begin
        state_nxt     = ST_IDLE;
        cmd_ready_nxt = 1'b1;
      end
      default: begin
        state_nxt     = ST_IDLE;
        cmd_ready_nxt = 1'b1;
        stb_nxt       = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
